// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constants, initial hash value, the
// compression helper functions and the controller state encoding.
// SHA256_DOUBLE_EN adds the PAD state used by the SHA256d second pass.
package sha256_pkg;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // H0 in the top word, matching the state_in/state_out packing
    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_COMPUTE,
        S_FINAL
`ifdef SHA256_DOUBLE_EN
        , S_PAD
`endif
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; working variables packed
// a..h with a in bits [255:224].
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] st_i,
    input  logic [31:0]  k_i,
    input  logic [31:0]  w_i,
    output logic [255:0] st_o
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = st_i;
    assign t1   = h + bsig1(e) + ch(e, f, g) + k_i + w_i;
    assign t2   = bsig0(a) + maj(a, b, c);
    assign st_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream_x.sv
// Streaming SHA-256 block engine: fetches 16 message words over a simple
// rq/rdy word bus, runs UNROLL rounds per clock, and accumulates into H.
// Define SHA256_DOUBLE_EN to enable the SHA256d second pass (dbl input).
module sha256_stream_x
    import sha256_pkg::*;
#(
    parameter int UNROLL = 1,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              chain,
    input  logic              dbl,
    output logic              rq,
    input  logic              rdy,
    output logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data,
    input  logic [255:0]      state_in,
    output logic [255:0]      state_out,
    output logic              busy,
    output logic              done
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("sha256_stream_x: UNROLL must be 1, 2 or 4");
    end
    if (ADDR_W < 4) begin : g_bad_addr
        $error("sha256_stream_x: ADDR_W must be at least 4");
    end

    state_t               state_q, state_d;
    logic [255:0]         h_q, h_d;      // digest accumulator H0..H7
    logic [255:0]         wv_q, wv_d;    // working variables a..h
    logic [15:0][31:0]    w_q, w_d;      // circular message schedule, slot = t mod 16
    logic [3:0]           wcnt_q, wcnt_d;
    logic [5:0]           rcnt_q, rcnt_d;
    logic                 rq_q, rq_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

`ifdef SHA256_DOUBLE_EN
    logic                 dbl_q, dbl_d;
    logic                 pass2_q, pass2_d;
`else
    logic                 unused_dbl;
    assign unused_dbl = dbl;
`endif

    logic [UNROLL-1:0][31:0] wout;       // schedule words for rounds rcnt..rcnt+UNROLL-1
    logic [255:0]            rnd_out;

    // Per-lane schedule word and round; W[t-2] comes from two lanes back
    // when it is produced in the same clock, otherwise from the buffer.
    for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
        logic [5:0]   t;
        logic [3:0]   s;
        logic [31:0]  w2;
        logic [31:0]  w;
        logic [255:0] st_i;
        logic [255:0] st_o;

        assign t = rcnt_q + 6'(j);
        assign s = t[3:0];

        if (j >= 2) begin : g_fwd
            assign w2 = g_rnd[j-2].w;
        end else begin : g_buf
            assign w2 = w_q[s - 4'd2];
        end

        assign w = (t < 6'd16) ? w_q[s]
                 : ssig1(w2) + w_q[s - 4'd7] + ssig0(w_q[s - 4'd15]) + w_q[s];
        assign wout[j] = w;

        if (j == 0) begin : g_first
            assign st_i = wv_q;
        end else begin : g_next
            assign st_i = g_rnd[j-1].st_o;
        end

        sha256_round u_round (
            .st_i (st_i),
            .k_i  (K[t]),
            .w_i  (w),
            .st_o (st_o)
        );
    end

    assign rnd_out = g_rnd[UNROLL-1].st_o;

    // Next-state logic for the controller, datapath and bus signals
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        wv_d    = wv_q;
        w_d     = w_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        rq_d    = rq_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SHA256_DOUBLE_EN
        dbl_d   = dbl_q;
        pass2_d = pass2_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    h_d     = chain ? h_q : state_in;
                    wv_d    = chain ? h_q : state_in;
                    wcnt_d  = 4'd0;
                    rq_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
`ifdef SHA256_DOUBLE_EN
                    dbl_d   = dbl;
                    pass2_d = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                if (rq_q && rdy) begin
                    w_d[wcnt_q] = data;
                    if (wcnt_q == 4'd15) begin
                        rq_d    = 1'b0;
                        wcnt_d  = 4'd0;
                        rcnt_d  = 6'd0;
                        state_d = S_COMPUTE;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
            end
            S_COMPUTE: begin
                wv_d = rnd_out;
                for (int j = 0; j < UNROLL; j++) begin
                    w_d[rcnt_q[3:0] + 4'(j)] = wout[j];
                end
                if (rcnt_q == 6'(64 - UNROLL)) begin
                    rcnt_d  = 6'd0;
                    state_d = S_FINAL;
                end else begin
                    rcnt_d = rcnt_q + 6'(UNROLL);
                end
            end
            S_FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    h_d[255-32*i -: 32] = h_q[255-32*i -: 32] + wv_q[255-32*i -: 32];
                end
`ifdef SHA256_DOUBLE_EN
                if (dbl_q && !pass2_q) begin
                    pass2_d = 1'b1;
                    state_d = S_PAD;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
`else
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
`endif
            end
`ifdef SHA256_DOUBLE_EN
            S_PAD: begin
                // 32-byte digest as the message of a single padded block
                for (int i = 0; i < 8; i++) begin
                    w_d[i] = h_q[255-32*i -: 32];
                end
                w_d[8] = 32'h80000000;
                for (int i = 9; i < 15; i++) begin
                    w_d[i] = 32'h0;
                end
                w_d[15] = 32'h00000100;
                h_d     = IV;
                wv_d    = IV;
                rcnt_d  = 6'd0;
                state_d = S_COMPUTE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset wipes every trace of a previous block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            wv_q    <= '0;
            w_q     <= '0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            rq_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHA256_DOUBLE_EN
            dbl_q   <= 1'b0;
            pass2_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            wv_q    <= wv_d;
            w_q     <= w_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            rq_q    <= rq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SHA256_DOUBLE_EN
            dbl_q   <= dbl_d;
            pass2_q <= pass2_d;
`endif
        end
    end

    // word counter is held at zero outside FETCH, so addr is too
    assign rq        = rq_q;
    assign addr      = ADDR_W'(wcnt_q);
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_out = h_q;

endmodule

// File: tb/tb_sha256_stream_x.sv
// Scoreboard bench for sha256_stream_x: stimulus pushes the expected digest
// and latency, a negedge monitor pops and compares on every done pulse.
module tb_sha256_stream_x;

    localparam int U = 1;
    localparam int LAT1 = 17 + 64 / U;
    localparam int LAT2 = 19 + 128 / U;

    localparam logic [255:0] IV_C = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] D_DBL = 256'h5df6e0e2_761359d3_0a827505_8e299fcc_03815345_45f55cf4_3e41983f_5d4c9456;

    localparam logic [511:0] B_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] B_M1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_M2 = {{15{32'h0}}, 32'h000001c0};

    logic         clk = 1'b0;
    logic         rst, start, chain, dbl, rq, rdy, busy, done;
    logic [3:0]   addr;
    logic [31:0]  data;
    logic [255:0] state_in, state_out;

    sha256_stream_x #(.UNROLL(U), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .chain(chain), .dbl(dbl),
        .rq(rq), .rdy(rdy), .addr(addr), .data(data),
        .state_in(state_in), .state_out(state_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] dig;
        bit           chk_dig;
        int           lat;
        int           t0;
        string        name;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [31:0] mem [16];
    bit          rnd_rdy = 1'b0;
    int          exp_addr = 0;

    always @(posedge clk) cyc++;

    // bus responder: serve mem[addr], check the addr order on each capture
    always @(negedge clk) begin
        if (!rst && rq) begin
            rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            data = mem[addr];
            if (rdy) begin
                checks++;
                if (int'(addr) != exp_addr) begin
                    errors++;
                    $display("FAIL addr_seq got=%0d want=%0d", addr, exp_addr);
                end
                exp_addr = (exp_addr + 1) % 16;
            end
        end else begin
            rdy = 1'b0;
            data = 32'h0;
        end
    end

    // monitor: idle bus must be quiet, each done pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            checks++;
            if (!rq && addr != 4'd0) begin
                errors++;
                $display("FAIL addr_idle got=%0d want=0", addr);
            end
            if (done) begin
                done_cnt++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    e = sbq.pop_front();
                    if (e.chk_dig) begin
                        checks++;
                        if (state_out !== e.dig) begin
                            errors++;
                            $display("FAIL %s_digest got=%h want=%h", e.name, state_out, e.dig);
                        end
                    end
                    if (e.lat >= 0) begin
                        checks++;
                        if (cyc - e.t0 != e.lat) begin
                            errors++;
                            $display("FAIL %s_latency got=%0d want=%0d", e.name, cyc - e.t0, e.lat);
                        end
                    end
                end
            end
        end
    end

    task automatic check1(input string nm, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got=busy want=idle");
        end
    endtask

    // issue one block; start is released after the accepting edge unless held
    task automatic start_block(input string nm, input logic [511:0] blk, input bit ch,
                               input bit db, input logic [255:0] sin, input bit push,
                               input logic [255:0] dig, input bit chk, input int lat,
                               input bit hold);
        exp_t e;
        wait_idle();
        @(negedge clk);
        for (int i = 0; i < 16; i++) mem[i] = blk[511-32*i -: 32];
        exp_addr = 0;
        state_in = sin;
        chain = ch;
        dbl = db;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        if (push) begin
            e.dig = dig;
            e.chk_dig = chk;
            e.lat = lat;
            e.t0 = cyc;
            e.name = nm;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=no_done want=done", nm);
            sbq.delete();
        end
    endtask

    initial begin
        exp_t e;
        int   d0;
        int   n;
        rst = 1'b1;
        start = 1'b0;
        chain = 1'b0;
        dbl = 1'b0;
        state_in = '0;
        repeat (3) @(negedge clk);
        check1("rst_rq", 256'(rq), 256'd0);
        check1("rst_done", 256'(done), 256'd0);
        check1("rst_busy", 256'(busy), 256'd0);
        check1("rst_addr", 256'(addr), 256'd0);
        check1("rst_state_out", state_out, 256'd0);
        rst = 1'b0;
        @(negedge clk);

        // "abc", bus always ready
        start_block("abc", B_ABC, 1'b0, 1'b0, IV_C, 1'b1, D_ABC, 1'b1, LAT1, 1'b0);
        wait_drain("abc", 400);

        // empty message with a randomly stalling bus
        rnd_rdy = 1'b1;
        start_block("empty_rnd", B_EMPTY, 1'b0, 1'b0, IV_C, 1'b1, D_EMPTY, 1'b1, -1, 1'b0);
        wait_drain("empty_rnd", 2000);
        rnd_rdy = 1'b0;

        // two-block message; second block chains from H, state_in ignored
        start_block("two_b1", B_M1, 1'b0, 1'b0, IV_C, 1'b1, '0, 1'b0, LAT1, 1'b0);
        wait_drain("two_b1", 400);
        start_block("two_b2", B_M2, 1'b1, 1'b0, 256'h0, 1'b1, D_TWO, 1'b1, LAT1, 1'b0);
        wait_drain("two_b2", 400);

        // dbl=1 on the empty message: SHA256d, or ignored without the feature
        d0 = done_cnt;
`ifdef SHA256_DOUBLE_EN
        start_block("dbl", B_EMPTY, 1'b0, 1'b1, IV_C, 1'b1, D_DBL, 1'b1, LAT2, 1'b0);
`else
        start_block("dbl", B_EMPTY, 1'b0, 1'b1, IV_C, 1'b1, D_EMPTY, 1'b1, LAT1, 1'b0);
`endif
        wait_drain("dbl", 800);
        repeat (LAT2 + 20) @(negedge clk);
        check1("dbl_done_count", 256'(done_cnt - d0), 256'd1);
        dbl = 1'b0;

        // reset around round 30 of COMPUTE, then a clean "abc"
        start_block("abc_abort", B_ABC, 1'b0, 1'b0, IV_C, 1'b0, '0, 1'b0, -1, 1'b0);
        repeat (16 + 30 / U) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check1("midrst_rq", 256'(rq), 256'd0);
        check1("midrst_done", 256'(done), 256'd0);
        check1("midrst_busy", 256'(busy), 256'd0);
        check1("midrst_state_out", state_out, 256'd0);
        rst = 1'b0;
        @(negedge clk);
        start_block("abc_after_rst", B_ABC, 1'b0, 1'b0, IV_C, 1'b1, D_ABC, 1'b1, LAT1, 1'b0);
        wait_drain("abc_after_rst", 400);

        // start held high: no restart while busy, next block right after done
        start_block("abc_hold1", B_ABC, 1'b0, 1'b0, IV_C, 1'b1, D_ABC, 1'b1, LAT1, 1'b1);
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL hold_timeout got=no_done want=done");
            sbq.delete();
        end else begin
            @(posedge clk);
            #1;
            e.dig = D_ABC;
            e.chk_dig = 1'b1;
            e.lat = LAT1;
            e.t0 = cyc;
            e.name = "abc_hold2";
            sbq.push_back(e);
            @(negedge clk);
            check1("hold_restart_busy", 256'(busy), 256'd1);
            check1("hold_restart_rq", 256'(rq), 256'd1);
            repeat (30) @(negedge clk);
            start = 1'b0;
            wait_drain("abc_hold2", 400);
        end
        start = 1'b0;

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
